vga_timing_decoder: RTL and testbench

Receive-side counterpart of the VGA output path. It samples the hsync/vsync/blank_b/RGB stream that the VGA controller and video generator drive, and recovers per-pixel x/y coordinates. It also measures line and frame geometry and declares lock once the geometry matches the expected mode for consecutive frames. It is used for loopback self-test of the display path and as the front end of any capture or overlay logic.

---
 rtl/vga_timing_decoder.sv | 243 ++++++++++++++++++++++++
 tb/tb_vga_timing_decoder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_decoder.sv
// vga_timing_decoder
// Samples an incoming VGA sync/blank/RGB stream, recovers pixel coordinates,
// measures line and frame geometry, and locks once the geometry matches the
// configured mode for LOCK_FRAMES consecutive frames.
module vga_timing_decoder #(
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        blank_b,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        pixel_valid,
    output logic [7:0]  r_o,
    output logic [7:0]  g_o,
    output logic [7:0]  b_o,
    output logic        line_start,
    output logic        frame_start,
    output logic        locked,
    output logic        sync_err,
    output logic [10:0] h_total_meas,
    output logic [10:0] v_total_meas,
    output logic [10:0] h_active_meas,
    output logic [10:0] v_active_meas
);

    localparam logic [10:0]    CNT_MAX = '1;
    localparam logic [10:0]    EXP_HT  = 11'(H_TOTAL);
    localparam logic [10:0]    EXP_VT  = 11'(V_TOTAL);
    localparam logic [10:0]    EXP_HA  = 11'(H_ACTIVE);
    localparam logic [10:0]    EXP_VA  = 11'(V_ACTIVE);
    localparam int unsigned    GW      = $clog2(LOCK_FRAMES + 1);
    localparam logic [GW-1:0]  LOCK_N  = GW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == CNT_MAX) ? v : v + 11'd1;
    endfunction

    // Input pipeline
    logic        hs1, vs1, bl1;
    logic        hs2, vs2, bl2;
    logic [23:0] rgb1;

    // Edge strobes
    logic hfall, vfall, act_start;

    // Geometry counters
    logic [10:0] hcnt, acnt, lcnt, y_cnt;

    // Values captured by the current cycle's edges (hfall applied before vfall)
    logic [10:0] h_total_nxt, h_active_nxt, lcnt_hf, ycnt_hf;
    logic        meas_ok, timeout;

    // Lock FSM
    state_t        state, state_nxt;
    logic [GW-1:0] good, good_nxt, good_inc;
    logic          locked_nxt, err_nxt;

    // Two-stage register of the pins; stage 2 only needs the control bits
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            hs1  <= 1'b0;
            vs1  <= 1'b0;
            bl1  <= 1'b0;
            rgb1 <= '0;
            hs2  <= 1'b0;
            vs2  <= 1'b0;
            bl2  <= 1'b0;
        end else begin
            hs1  <= hsync;
            vs1  <= vsync;
            bl1  <= blank_b;
            rgb1 <= {r, g, b};
            hs2  <= hs1;
            vs2  <= vs1;
            bl2  <= bl1;
        end
    end

    // Edge decode from the two pipeline stages
    always_comb begin
        hfall     = hs2 & ~hs1;
        vfall     = vs2 & ~vs1;
        act_start = bl1 & ~bl2;
    end

    // Line-end updates folded first so a coincident vfall sees the finished line
    always_comb begin
        h_total_nxt  = h_total_meas;
        h_active_nxt = h_active_meas;
        lcnt_hf      = lcnt;
        ycnt_hf      = y_cnt;
        if (hfall) begin
            h_total_nxt  = sat_inc(hcnt);
            h_active_nxt = acnt;
            lcnt_hf      = sat_inc(lcnt);
            if (acnt != '0) begin
                ycnt_hf = sat_inc(y_cnt);
            end
        end
        meas_ok = (h_total_nxt == EXP_HT) && (h_active_nxt == EXP_HA) &&
                  (lcnt_hf == EXP_VT) && (ycnt_hf == EXP_VA);
        timeout = (hcnt == CNT_MAX);
    end

    // Line/frame counters and measurement capture
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            hcnt          <= '0;
            acnt          <= '0;
            lcnt          <= '0;
            y_cnt         <= '0;
            h_total_meas  <= '0;
            h_active_meas <= '0;
            v_total_meas  <= '0;
            v_active_meas <= '0;
        end else begin
            hcnt          <= hfall ? '0 : sat_inc(hcnt);
            acnt          <= hfall ? '0 : (bl1 ? sat_inc(acnt) : acnt);
            h_total_meas  <= h_total_nxt;
            h_active_meas <= h_active_nxt;
            if (vfall) begin
                v_total_meas  <= lcnt_hf;
                v_active_meas <= ycnt_hf;
                lcnt          <= '0;
                y_cnt         <= '0;
            end else begin
                lcnt  <= lcnt_hf;
                y_cnt <= ycnt_hf;
            end
        end
    end

    // Pixel data, valid flag, x coordinate and sync strobes
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            pixel_valid <= 1'b0;
            r_o         <= '0;
            g_o         <= '0;
            b_o         <= '0;
            x           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pixel_valid       <= bl1;
            {r_o, g_o, b_o}   <= rgb1;
            line_start        <= hfall;
            frame_start       <= vfall;
            if (act_start) begin
                x <= '0;
            end else if (bl1 && (x != '1)) begin
                x <= x + 10'd1;
            end
        end
    end

    // y is the line count clamped to the 10-bit coordinate range
    always_comb begin
        y = (y_cnt > 11'd1023) ? 10'd1023 : y_cnt[9:0];
    end

    // Lock FSM state register
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state <= SEARCH;
            good  <= '0;
        end else begin
            state <= state_nxt;
            good  <= good_nxt;
        end
    end

    // Lock FSM next state: missing hsync overrides any frame judgement
    always_comb begin
        state_nxt = state;
        good_nxt  = good;
        good_inc  = good + GW'(1);
        if (timeout) begin
            state_nxt = SEARCH;
            good_nxt  = '0;
        end else if (vfall) begin
            case (state)
                SEARCH: begin
                    state_nxt = CHECK;
                    good_nxt  = '0;
                end
                CHECK: begin
                    if (meas_ok) begin
                        good_nxt = good_inc;
                        if (good_inc == LOCK_N) begin
                            state_nxt = LOCKED;
                        end
                    end else begin
                        good_nxt = '0;
                    end
                end
                LOCKED: begin
                    if (!meas_ok) begin
                        state_nxt = SEARCH;
                        good_nxt  = '0;
                    end
                end
                default: begin
                    state_nxt = SEARCH;
                    good_nxt  = '0;
                end
            endcase
        end
    end

    // Lock FSM outputs: derived from the next state so they align with the measurements
    always_comb begin
        locked_nxt = (state_nxt == LOCKED);
        err_nxt    = (state != SEARCH) && (state_nxt == SEARCH);
    end

    // Registered lock status and error pulse
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            locked   <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            locked   <= locked_nxt;
            sync_err <= err_nxt;
        end
    end

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Directed bench for vga_timing_decoder using a reduced video mode
// (40 clocks x 12 lines, 24 x 8 active) so that several frames fit in a short run.
module tb_vga_timing_decoder;

    localparam int HT = 40;
    localparam int VT = 12;
    localparam int HA = 24;
    localparam int VA = 8;
    localparam int LF = 2;
    localparam int HS_W     = 4;   // hsync low for px 0..3
    localparam int HA_FIRST = 8;   // active px 8..31
    localparam int VS_L     = 2;   // vsync low for lines 0..1
    localparam int VA_FIRST = 4;   // active lines 4..11 (last line of the frame)

    logic        clk;
    logic        reset_b;
    logic        hsync, vsync, blank_b;
    logic [7:0]  r, g, b;
    logic [9:0]  x, y;
    logic        pixel_valid;
    logic [7:0]  r_o, g_o, b_o;
    logic        line_start, frame_start, locked, sync_err;
    logic [10:0] h_total_meas, v_total_meas, h_active_meas, v_active_meas;

    int n_checks = 0;
    int n_fail   = 0;
    int err_count = 0;
    bit rst_done = 0;
    int ln, px;
    bit short_last = 0;
    bit sync_hold  = 0;

    vga_timing_decoder #(
        .H_TOTAL    (HT),
        .V_TOTAL    (VT),
        .H_ACTIVE   (HA),
        .V_ACTIVE   (VA),
        .LOCK_FRAMES(LF)
    ) dut (
        .clk          (clk),
        .reset_b      (reset_b),
        .hsync        (hsync),
        .vsync        (vsync),
        .blank_b      (blank_b),
        .r            (r),
        .g            (g),
        .b            (b),
        .x            (x),
        .y            (y),
        .pixel_valid  (pixel_valid),
        .r_o          (r_o),
        .g_o          (g_o),
        .b_o          (b_o),
        .line_start   (line_start),
        .frame_start  (frame_start),
        .locked       (locked),
        .sync_err     (sync_err),
        .h_total_meas (h_total_meas),
        .v_total_meas (v_total_meas),
        .h_active_meas(h_active_meas),
        .v_active_meas(v_active_meas)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_done && reset_b && sync_err === 1'b1) err_count++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one clock of the stream at the falling edge, then advance position
    task automatic step();
        int len;
        @(negedge clk);
        hsync   = sync_hold ? 1'b1 : (px >= HS_W);
        vsync   = sync_hold ? 1'b1 : (ln >= VS_L);
        blank_b = (ln >= VA_FIRST) && (px >= HA_FIRST) && (px < HA_FIRST + HA);
        if (blank_b) begin
            r = 8'h11 + 8'(px - HA_FIRST);
            g = 8'h22 + 8'(ln - VA_FIRST);
            b = 8'h33;
        end else begin
            r = '0;
            g = '0;
            b = '0;
        end
        len = (short_last && ln == VT - 1) ? HT - 1 : HT;
        px++;
        if (px >= len) begin
            px = 0;
            ln = (ln + 1) % VT;
        end
    endtask

    task automatic advance_to(input int l, input int p);
        int guard = 0;
        while (!(ln == l && px == p) && guard < 2000) begin
            step();
            guard++;
        end
        chk("reach_position", 32'(guard < 2000), 1);
    endtask

    task automatic chk_reset_zero();
        chk("rst_xy",     32'({x, y}), 0);
        chk("rst_pixel",  32'({pixel_valid, r_o, g_o, b_o}), 0);
        chk("rst_flags",  32'({line_start, frame_start, locked, sync_err}), 0);
        chk("rst_meas_h", 32'({h_total_meas, h_active_meas}), 0);
        chk("rst_meas_v", 32'({v_total_meas, v_active_meas}), 0);
    endtask

    initial begin
        int cnt;
        reset_b = 1'b1;
        hsync = 1'b1; vsync = 1'b1; blank_b = 1'b0;
        r = '0; g = '0; b = '0;
        ln = 5; px = 10;

        // Stream already running; reset lands mid-frame for 3 clocks
        repeat (3) step();
        reset_b  = 1'b0;
        rst_done = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk_reset_zero();
            step();
        end
        reset_b = 1'b1;

        // vfall 1: partial frame, not judged
        advance_to(0, 0); step(); step(); step();
        chk("frame_start_v1", 32'(frame_start), 1);
        chk("locked_v1", 32'(locked), 0);

        // vfall 2: first full frame
        advance_to(0, 0); step(); step();
        chk("frame_start_latency", 32'(frame_start), 0);
        step();
        chk("frame_start_v2", 32'(frame_start), 1);
        chk("line_start_v2", 32'(line_start), 1);
        chk("locked_v2", 32'(locked), 0);
        chk("h_total_meas", 32'(h_total_meas), HT);
        chk("h_active_meas", 32'(h_active_meas), HA);
        chk("v_total_meas", 32'(v_total_meas), VT);
        chk("v_active_meas", 32'(v_active_meas), VA);
        step();
        chk("line_start_pulse", 32'(line_start), 0);

        // First and last active pixel of frame 3
        advance_to(VA_FIRST, HA_FIRST); step(); step(); step();
        chk("first_x", 32'(x), 0);
        chk("first_y", 32'(y), 0);
        chk("first_valid", 32'(pixel_valid), 1);
        chk("first_rgb", 32'({r_o, g_o, b_o}), 32'h112233);
        step();
        chk("second_x", 32'(x), 1);
        chk("second_r", 32'(r_o), 32'h12);
        advance_to(VT - 1, HA_FIRST + HA - 1); step(); step(); step();
        chk("last_x", 32'(x), HA - 1);
        chk("last_y", 32'(y), VA - 1);
        chk("last_valid", 32'(pixel_valid), 1);
        chk("last_rgb", 32'({r_o, g_o, b_o}), 32'h282933);
        step();
        chk("after_last_valid", 32'(pixel_valid), 0);
        chk("after_last_x_held", 32'(x), HA - 1);

        // vfall 3: lock, hsync and vsync fall on the same clock
        advance_to(0, 0); step(); step();
        chk("locked_before", 32'(locked), 0);
        step();
        chk("locked_v3", 32'(locked), 1);
        chk("v_total_coincident", 32'(v_total_meas), VT);
        chk("v_active_coincident", 32'(v_active_meas), VA);
        chk("no_sync_err", 32'(err_count), 0);

        // Frame 4 restarts y at 0; its last line is one clock short
        advance_to(VA_FIRST, HA_FIRST); step(); step(); step();
        chk("y_restart", 32'(y), 0);
        chk("x_restart", 32'(x), 0);
        short_last = 1'b1;
        advance_to(0, 0);
        short_last = 1'b0;
        step(); step();
        chk("short_err_early", 32'(sync_err), 0);
        step();
        chk("short_sync_err", 32'(sync_err), 1);
        chk("short_locked", 32'(locked), 0);
        chk("short_h_total", 32'(h_total_meas), HT - 1);
        chk("short_h_active", 32'(h_active_meas), HA);
        step();
        chk("short_err_pulse", 32'(sync_err), 0);
        chk("err_count_1", 32'(err_count), 1);

        // Relock: SEARCH -> CHECK -> good=1 -> LOCKED
        advance_to(0, 0); step(); step(); step();
        chk("relock_v5", 32'(locked), 0);
        advance_to(0, 0); step(); step(); step();
        chk("relock_v6", 32'(locked), 0);
        advance_to(0, 0); step(); step(); step();
        chk("relock_v7", 32'(locked), 1);

        // Timeout: last hfall driven, then syncs held high
        advance_to(1, 0); step();
        sync_hold = 1'b1;
        cnt = 0;
        while (cnt < 2100) begin
            step();
            cnt++;
            if (sync_err === 1'b1) break;
        end
        chk("timeout_latency", 32'(cnt), 2050);
        chk("timeout_locked", 32'(locked), 0);
        step();
        chk("timeout_err_pulse", 32'(sync_err), 0);
        chk("err_count_2", 32'(err_count), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
